alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request; samples op, x and y in the same cycle when busy=0.
REQ-005 SHALL have port op  input  14  one-hot opcode: 0 ADD, 1 SUB, 2 INX, 3 DCX, 4 CPX, 5 SHL, 6 SHR, 7 SRA, 8 AND, 9 OR, 10 XOR, 11 NOT, 12 MUL (unsigned), 13 DIV (unsigned).
REQ-006 SHALL have ports x, y  input  WIDTH  operands.
REQ-007 SHALL have port z  output  WIDTH  result (MUL low half, DIV quotient).
REQ-008 SHALL have port z_hi  output  WIDTH  MUL high half, DIV remainder, else 0.
REQ-009 SHALL have port flags  output  4  bit 0 ZF, bit 1 SF, bit 2 OF, bit 3 CF.
REQ-010 SHALL have port busy  output  1  high while a multi-cycle op iterates.
REQ-011 SHALL have port done  output  1  one-cycle pulse; z, z_hi, flags and err are valid.
REQ-012 SHALL have port err  output  1  set with done for an illegal opcode or divide-by-zero.

Function
REQ-013 SHALL have states IDLE, MUL, DIV: start with MUL goes IDLE->MUL; start with DIV and y!=0 goes IDLE->DIV; after WIDTH iterations, MUL/DIV->IDLE.
REQ-014 Ops 0-11 SHALL assert done in cycle N+1 for start sampled in cycle N, with registered results.
REQ-015 MUL SHALL be shift-add, DIV restoring; each SHALL assert done exactly WIDTH+1 cycles after start, with busy high for cycles N+1..N+WIDTH.
REQ-016 Start with busy=1 SHALL be ignored and SHALL NOT corrupt the operation in flight.
REQ-017 Outputs z, z_hi, flags and err SHALL hold their values until the next done.
REQ-018 ADD/SUB/INX/DCX SHALL compute x+y, x-y, x+1 and x-1 modulo 2^WIDTH.
REQ-019 For these arithmetic ops, CF SHALL be the adder carry-out (SUB: 1 = no borrow) and OF SHALL be two's-complement overflow.
REQ-020 CPX SHALL return x; SHL/SHR/SRA SHALL shift x by y[log2(WIDTH)-1:0] bits; SRA SHALL sign-fill; shifts SHALL set OF=CF=0.
REQ-021 Logic ops SHALL return x&y, x|y, x^y and ~x, with OF=CF=0 and SF=0.
REQ-022 ZF SHALL equal (z==0); SF SHALL equal z[WIDTH-1] for arithmetic, shift, MUL and DIV ops.
REQ-023 MUL SHALL set OF=CF=(z_hi!=0); DIV SHALL set OF=CF=0.
REQ-024 DIV with y=0 SHALL complete in 1 cycle with z all ones, z_hi=x, flags=0, err=1.
REQ-025 An op that is not exactly one-hot SHALL complete in 1 cycle with z=0, z_hi=0, flags=4'b0001, err=1.

Reset
REQ-026 With rst high at a rising edge, the block SHALL go to IDLE with busy=0, done=0, err=0, z=0, z_hi=0, flags=0 and iteration counter 0.
REQ-027 Reset SHALL take priority over start, and reset during MUL/DIV SHALL abort with no done pulse.

Structure
REQ-028 Shared package alu_pkg SHALL hold opcode bit indices, flag bit indices and the state encoding.
REQ-029 A single sub-module, add_sub_w (parametrised WIDTH adder/subtractor with OF and CF), SHALL be instantiated for ADD/SUB/INX/DCX.

Verification
REQ-030 WIDTH=32, ADD x=0x7FFFFFFF y=1 -> done at N+1, z=0x80000000, OF=1, SF=1, CF=0, ZF=0.
REQ-031 SUB x=5 y=5 -> z=0, ZF=1, CF=1; SRA x=0x80000000 y=4 -> z=0xF8000000, SF=1.
REQ-032 MUL x=0xFFFFFFFF y=2 -> done exactly at N+33, z=0xFFFFFFFE, z_hi=1, CF=OF=1, busy high for 32 cycles.
REQ-033 DIV x=100 y=7 -> z=14, z_hi=2, done at N+33; DIV y=0 -> done at N+1, err=1, z=0xFFFFFFFF.
REQ-034 Start ADD in cycle N+5 of a MUL -> ignored, MUL result unchanged; op=0x0003 -> err=1, ZF=1.
REQ-035 rst at cycle N+10 of a DIV -> no done, all outputs 0 at next cycle, next ADD 2+3 -> z=5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode/flag bit positions,
// controller state encoding and small helpers.
package alu_pkg;

    localparam int NUM_OPS = 14;

    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_INX = 2;
    localparam int OP_DCX = 3;
    localparam int OP_CPX = 4;
    localparam int OP_SHL = 5;
    localparam int OP_SHR = 6;
    localparam int OP_SRA = 7;
    localparam int OP_AND = 8;
    localparam int OP_OR  = 9;
    localparam int OP_XOR = 10;
    localparam int OP_NOT = 11;
    localparam int OP_MUL = 12;
    localparam int OP_DIV = 13;

    localparam logic [NUM_OPS-1:0] OH_ADD = 14'd1 << OP_ADD;
    localparam logic [NUM_OPS-1:0] OH_SUB = 14'd1 << OP_SUB;
    localparam logic [NUM_OPS-1:0] OH_INX = 14'd1 << OP_INX;
    localparam logic [NUM_OPS-1:0] OH_DCX = 14'd1 << OP_DCX;
    localparam logic [NUM_OPS-1:0] OH_CPX = 14'd1 << OP_CPX;
    localparam logic [NUM_OPS-1:0] OH_SHL = 14'd1 << OP_SHL;
    localparam logic [NUM_OPS-1:0] OH_SHR = 14'd1 << OP_SHR;
    localparam logic [NUM_OPS-1:0] OH_SRA = 14'd1 << OP_SRA;
    localparam logic [NUM_OPS-1:0] OH_AND = 14'd1 << OP_AND;
    localparam logic [NUM_OPS-1:0] OH_OR  = 14'd1 << OP_OR;
    localparam logic [NUM_OPS-1:0] OH_XOR = 14'd1 << OP_XOR;
    localparam logic [NUM_OPS-1:0] OH_NOT = 14'd1 << OP_NOT;
    localparam logic [NUM_OPS-1:0] OH_DIV = 14'd1 << OP_DIV;

    localparam int FLAG_ZF = 0;
    localparam int FLAG_SF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_CF = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    function automatic logic is_onehot(input logic [NUM_OPS-1:0] v);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < NUM_OPS; i++) begin
            cnt = cnt + {4'd0, v[i]};
        end
        return (cnt == 5'd1);
    endfunction

    function automatic logic [3:0] pack_flags(input logic zf, input logic sf,
                                              input logic of, input logic cf);
        logic [3:0] f;
        f          = 4'd0;
        f[FLAG_ZF] = zf;
        f[FLAG_SF] = sf;
        f[FLAG_OF] = of;
        f[FLAG_CF] = cf;
        return f;
    endfunction

endpackage

// File: rtl/add_sub_w.sv
// WIDTH-bit adder/subtractor; for subtraction cf is the carry out of
// a + ~b + 1, so cf=1 means no borrow.
module add_sub_w #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cf,
    output logic             of
);

    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH:0]   full_s;

    // Two's-complement add with carry-in for subtraction, plus overflow detect
    always_comb begin
        b_eff_s = sub ? ~b : b;
        full_s  = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, sub};
        sum     = full_s[WIDTH-1:0];
        cf      = full_s[WIDTH];
        of      = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (full_s[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/shift/logic ops, WIDTH-iteration
// shift-add multiply and restoring divide, all results registered.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [13:0]        op,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic [WIDTH-1:0]   z,
    output logic [WIDTH-1:0]   z_hi,
    output logic [3:0]         flags,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = SH_W + 1;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   m_r;

    logic [WIDTH-1:0]   as_b_s;
    logic               as_sub_s;
    logic [WIDTH-1:0]   as_sum_s;
    logic               as_cf_s;
    logic               as_of_s;

    logic               op_ok_s;
    logic [SH_W-1:0]    sh_s;
    logic [WIDTH-1:0]   res_z_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic               res_of_s;
    logic               res_cf_s;
    logic               res_sf_en_s;
    logic               res_err_s;
    logic [3:0]         res_flags_s;

    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH-1:0]   mul_hi_nx_s;
    logic [WIDTH-1:0]   mul_lo_nx_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_trial_s;
    logic [WIDTH-1:0]   div_rem_nx_s;
    logic [WIDTH-1:0]   div_q_nx_s;
    logic               last_s;

    add_sub_w #(.WIDTH(WIDTH)) u_add_sub (
        .a   (x),
        .b   (as_b_s),
        .sub (as_sub_s),
        .sum (as_sum_s),
        .cf  (as_cf_s),
        .of  (as_of_s)
    );

    // Adder operand selection: INX/DCX reuse the adder with a constant one
    always_comb begin
        as_b_s   = y;
        as_sub_s = 1'b0;
        if (op == OH_SUB) begin
            as_sub_s = 1'b1;
        end else if (op == OH_INX) begin
            as_b_s = ONE;
        end else if (op == OH_DCX) begin
            as_b_s   = ONE;
            as_sub_s = 1'b1;
        end else begin
            as_sub_s = 1'b0;
        end
    end

    // Single-cycle result, including divide-by-zero and illegal-opcode results
    always_comb begin
        op_ok_s     = is_onehot(op);
        sh_s        = y[SH_W-1:0];
        res_z_s     = '0;
        res_hi_s    = '0;
        res_of_s    = 1'b0;
        res_cf_s    = 1'b0;
        res_sf_en_s = 1'b0;
        res_err_s   = 1'b0;
        if (!op_ok_s) begin
            res_err_s = 1'b1;
        end else begin
            case (op)
                OH_ADD, OH_SUB, OH_INX, OH_DCX: begin
                    res_z_s     = as_sum_s;
                    res_of_s    = as_of_s;
                    res_cf_s    = as_cf_s;
                    res_sf_en_s = 1'b1;
                end
                OH_CPX: begin
                    res_z_s     = x;
                    res_sf_en_s = 1'b1;
                end
                OH_SHL: begin
                    res_z_s     = x << sh_s;
                    res_sf_en_s = 1'b1;
                end
                OH_SHR: begin
                    res_z_s     = x >> sh_s;
                    res_sf_en_s = 1'b1;
                end
                OH_SRA: begin
                    res_z_s     = $signed(x) >>> sh_s;
                    res_sf_en_s = 1'b1;
                end
                OH_AND: res_z_s = x & y;
                OH_OR:  res_z_s = x | y;
                OH_XOR: res_z_s = x ^ y;
                OH_NOT: res_z_s = ~x;
                OH_DIV: begin
                    // only reached here as a single-cycle op when y == 0
                    res_z_s   = '1;
                    res_hi_s  = x;
                    res_err_s = 1'b1;
                end
                default: res_z_s = '0;
            endcase
        end
        res_flags_s = pack_flags((res_z_s == '0), res_sf_en_s & res_z_s[WIDTH-1],
                                 res_of_s, res_cf_s);
    end

    // One multiply step (shift-add) and one divide step (restoring)
    always_comb begin
        mul_sum_s   = {1'b0, acc_r} + ({1'b0, m_r} & {(WIDTH+1){b_r[0]}});
        mul_hi_nx_s = mul_sum_s[WIDTH:1];
        mul_lo_nx_s = {mul_sum_s[0], b_r[WIDTH-1:1]};
        div_shift_s = {acc_r, b_r[WIDTH-1]};
        div_trial_s = div_shift_s - {1'b0, m_r};
        if (div_trial_s[WIDTH]) begin
            div_rem_nx_s = div_shift_s[WIDTH-1:0];
            div_q_nx_s   = {b_r[WIDTH-2:0], 1'b0};
        end else begin
            div_rem_nx_s = div_trial_s[WIDTH-1:0];
            div_q_nx_s   = {b_r[WIDTH-2:0], 1'b1};
        end
        last_s = (cnt_r == CNT_W'(WIDTH - 1));
    end

    // Controller FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            acc_r   <= '0;
            b_r     <= '0;
            m_r     <= '0;
            z       <= '0;
            z_hi    <= '0;
            flags   <= 4'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (op_ok_s && op[OP_MUL]) begin
                            state_r <= ST_MUL;
                            busy    <= 1'b1;
                            cnt_r   <= '0;
                            acc_r   <= '0;
                            b_r     <= y;
                            m_r     <= x;
                        end else if (op_ok_s && op[OP_DIV] && (y != '0)) begin
                            state_r <= ST_DIV;
                            busy    <= 1'b1;
                            cnt_r   <= '0;
                            acc_r   <= '0;
                            b_r     <= x;
                            m_r     <= y;
                        end else begin
                            done  <= 1'b1;
                            z     <= res_z_s;
                            z_hi  <= res_hi_s;
                            flags <= res_flags_s;
                            err   <= res_err_s;
                        end
                    end
                end
                ST_MUL: begin
                    acc_r <= mul_hi_nx_s;
                    b_r   <= mul_lo_nx_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        z       <= mul_lo_nx_s;
                        z_hi    <= mul_hi_nx_s;
                        flags   <= pack_flags((mul_lo_nx_s == '0), mul_lo_nx_s[WIDTH-1],
                                              (mul_hi_nx_s != '0), (mul_hi_nx_s != '0));
                        err     <= 1'b0;
                    end
                end
                ST_DIV: begin
                    acc_r <= div_rem_nx_s;
                    b_r   <= div_q_nx_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        z       <= div_q_nx_s;
                        z_hi    <= div_rem_nx_s;
                        flags   <= pack_flags((div_q_nx_s == '0), div_q_nx_s[WIDTH-1],
                                              1'b0, 1'b0);
                        err     <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=32): expectations queued at issue time,
// checked with latency and busy-length when done pulses.
module tb_alu_seq;

    localparam int W = 32;
    localparam logic [13:0] O_ADD = 14'h0001;
    localparam logic [13:0] O_SUB = 14'h0002;
    localparam logic [13:0] O_INX = 14'h0004;
    localparam logic [13:0] O_DCX = 14'h0008;
    localparam logic [13:0] O_CPX = 14'h0010;
    localparam logic [13:0] O_SHL = 14'h0020;
    localparam logic [13:0] O_SHR = 14'h0040;
    localparam logic [13:0] O_SRA = 14'h0080;
    localparam logic [13:0] O_AND = 14'h0100;
    localparam logic [13:0] O_OR  = 14'h0200;
    localparam logic [13:0] O_XOR = 14'h0400;
    localparam logic [13:0] O_NOT = 14'h0800;
    localparam logic [13:0] O_MUL = 14'h1000;
    localparam logic [13:0] O_DIV = 14'h2000;

    typedef struct {
        string        tag;
        logic [W-1:0] z;
        logic [W-1:0] hi;
        logic [3:0]   f;
        logic         e;
        int           cyc;
        int           bsy;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [13:0]  op = 14'h0;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic [W-1:0] z;
    logic [W-1:0] z_hi;
    logic [3:0]   flags;
    logic         busy;
    logic         done;
    logic         err;

    int   n_assert = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    exp_t sb[$];
    exp_t got;
    int   n_mul;

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .x     (x),
        .y     (y),
        .z     (z),
        .z_hi  (z_hi),
        .flags (flags),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: compare every done pulse against the oldest expectation
    always @(negedge clk) begin
        if (done) begin
            chk("unexpected_done", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                got = sb.pop_front();
                chk({got.tag, "_z"}, 64'(z), 64'(got.z));
                chk({got.tag, "_zhi"}, 64'(z_hi), 64'(got.hi));
                chk({got.tag, "_flags"}, 64'(flags), 64'(got.f));
                chk({got.tag, "_err"}, 64'(err), 64'(got.e));
                chk({got.tag, "_latency"}, 64'(cyc), 64'(got.cyc));
                chk({got.tag, "_busy_cycles"}, 64'(busy_cnt), 64'(got.bsy));
            end
            busy_cnt = 0;
        end else if (busy) begin
            busy_cnt++;
        end else begin
            busy_cnt = 0;
        end
    end

    task automatic issue(input string tag, input logic [13:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic push, input logic [W-1:0] ez,
                         input logic [W-1:0] ehi, input logic [3:0] ef, input logic ee,
                         input int lat);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        x     = a;
        y     = b;
        if (push) begin
            e.tag = tag;
            e.z   = ez;
            e.hi  = ehi;
            e.f   = ef;
            e.e   = ee;
            e.cyc = cyc + lat;
            e.bsy = (lat > 1) ? lat - 1 : 0;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_z", 64'(z), 64'd0);
        chk("rst_zhi", 64'(z_hi), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_busy_done_err", 64'({busy, done, err}), 64'd0);
        rst = 1'b0;

        // flags literal order: {CF, OF, SF, ZF}
        issue("add_ovf", O_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1, 32'h8000_0000, 32'h0, 4'b0110, 1'b0, 1);
        issue("sub_zero", O_SUB, 32'h5, 32'h5, 1'b1, 32'h0, 32'h0, 4'b1001, 1'b0, 1);
        issue("sub_borrow", O_SUB, 32'h3, 32'h5, 1'b1, 32'hFFFF_FFFE, 32'h0, 4'b0010, 1'b0, 1);
        issue("sub_ovf", O_SUB, 32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 32'h0, 4'b1100, 1'b0, 1);
        issue("inx_wrap", O_INX, 32'hFFFF_FFFF, 32'h1234, 1'b1, 32'h0, 32'h0, 4'b1001, 1'b0, 1);
        issue("dcx_wrap", O_DCX, 32'h0, 32'h1234, 1'b1, 32'hFFFF_FFFF, 32'h0, 4'b0010, 1'b0, 1);
        issue("cpx", O_CPX, 32'h0, 32'hFFFF, 1'b1, 32'h0, 32'h0, 4'b0001, 1'b0, 1);
        issue("sra", O_SRA, 32'h8000_0000, 32'h4, 1'b1, 32'hF800_0000, 32'h0, 4'b0010, 1'b0, 1);
        issue("shl31", O_SHL, 32'h1, 32'd31, 1'b1, 32'h8000_0000, 32'h0, 4'b0010, 1'b0, 1);
        issue("shl_mod", O_SHL, 32'h1, 32'd33, 1'b1, 32'h2, 32'h0, 4'b0000, 1'b0, 1);
        issue("shr", O_SHR, 32'h8000_0000, 32'd31, 1'b1, 32'h1, 32'h0, 4'b0000, 1'b0, 1);
        issue("and", O_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1, 32'h00F0_00F0, 32'h0, 4'b0000, 1'b0, 1);
        issue("or", O_OR, 32'hF000_0000, 32'h1, 1'b1, 32'hF000_0001, 32'h0, 4'b0000, 1'b0, 1);
        issue("xor", O_XOR, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 32'h0, 32'h0, 4'b0001, 1'b0, 1);
        issue("not", O_NOT, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'h0, 4'b0000, 1'b0, 1);
        issue("illegal", 14'h0003, 32'h7, 32'h9, 1'b1, 32'h0, 32'h0, 4'b0001, 1'b1, 1);
        issue("illegal0", 14'h0000, 32'h7, 32'h9, 1'b1, 32'h0, 32'h0, 4'b0001, 1'b1, 1);
        drain();

        issue("mul_ff_2", O_MUL, 32'hFFFF_FFFF, 32'h2, 1'b1, 32'hFFFF_FFFE, 32'h1, 4'b1110, 1'b0, 33);
        drain();
        issue("mul_zero", O_MUL, 32'h0, 32'h5, 1'b1, 32'h0, 32'h0, 4'b0001, 1'b0, 33);
        drain();
        issue("div_100_7", O_DIV, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 4'b0000, 1'b0, 33);
        drain();
        issue("div_big", O_DIV, 32'hFFFF_FFFF, 32'h10, 1'b1, 32'h0FFF_FFFF, 32'hF, 4'b0000, 1'b0, 33);
        drain();
        issue("div_by0", O_DIV, 32'd100, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd100, 4'b0000, 1'b1, 1);
        drain();

        // ADD request at cycle N+5 of a multiply must be dropped
        issue("mul_busy", O_MUL, 32'h1234_5678, 32'h10, 1'b1, 32'h2345_6780, 32'h1, 4'b1100, 1'b0, 33);
        repeat (3) @(negedge clk);
        issue("ignored_add", O_ADD, 32'h1, 32'h1, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 1);
        drain();

        // Reset at cycle N+10 of a divide aborts it without a done pulse
        n_mul = 0;
        issue("div_abort", O_DIV, 32'd1000, 32'd3, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 33);
        repeat (8) @(negedge clk);
        chk("abort_busy_before_rst", 64'(busy), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_z", 64'(z), 64'd0);
        chk("abort_zhi", 64'(z_hi), 64'd0);
        chk("abort_flags", 64'(flags), 64'd0);
        chk("abort_busy_done_err", 64'({busy, done, err}), 64'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) n_mul++;
        end
        chk("abort_no_done", 64'(n_mul), 64'd0);
        issue("add_after_rst", O_ADD, 32'd2, 32'd3, 1'b1, 32'd5, 32'h0, 4'b0000, 1'b0, 1);
        drain();
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
